dist_fix_sq_accum: RTL and testbench

// - Downstream stage of the signed 17x17 -> 34-bit fixed-point multiplier in the distance datapath.
// - Accumulates a frame of products (squared coordinate differences) into a wide saturating accumulator.
// - Rescales the frame total and saturates it, then emits one squared-distance result per frame.
// - Input and output use valid/ready handshakes; each frame is delimited by s_last.

---
 rtl/dist_fix_pkg.sv | 26 ++
 rtl/dist_fix_sat_add.sv | 22 ++
 rtl/dist_fix_sq_accum.sv | 92 +++++++++
 tb/tb_dist_fix_sq_accum.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dist_fix_pkg.sv
// Shared types, default widths and the signed clamp helper for the distance
// accumulator stage.
package dist_fix_pkg;

  typedef enum logic {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_e;

  localparam int PROD_W = 34;
  localparam int ACC_W  = 40;
  localparam int OUT_W  = 32;
  localparam int CNT_W  = 16;

  // Clamp a sign-extended value into a signed field of 'width' bits (width <= 64).
  function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] value,
                                                    input int                 width);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi)      return hi;
    else if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/dist_fix_sat_add.sv
// Combinational W-bit signed saturating adder; ovf flags that the clamp fired.
module dist_fix_sat_add #(
  parameter int W = dist_fix_pkg::ACC_W
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                ovf
);

  logic signed [W-1:0] raw;

  assign raw = a + b;
  // Overflow only when both operands share a sign and the result flips it.
  assign ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);

  always_comb begin
    sum = raw;
    if (ovf) sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end

endmodule

// File: rtl/dist_fix_sq_accum.sv
// Frame accumulator for squared coordinate differences: saturating sum per
// frame, rescale, clamp, and one result per s_last-delimited frame.
module dist_fix_sq_accum
  import dist_fix_pkg::*;
#(
  parameter int PROD_W = dist_fix_pkg::PROD_W,
  parameter int ACC_W  = dist_fix_pkg::ACC_W,
  parameter int OUT_W  = dist_fix_pkg::OUT_W,
  parameter int SHIFT  = 0,
  parameter int CNT_W  = dist_fix_pkg::CNT_W
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [PROD_W-1:0] s_data,
  input  logic                     s_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [OUT_W-1:0]  m_data,
  output logic                     m_ovf,
  output logic        [CNT_W-1:0]  m_count
);

  state_e                    state;
  logic signed [ACC_W-1:0]   acc, s_ext, sum, shifted;
  logic        [CNT_W-1:0]   cnt, cnt_inc;
  logic                      ovf, add_ovf, out_clamp;
  logic signed [63:0]        wide, clamped;
  logic signed [OUT_W-1:0]   out_val;

  assign s_ext = ACC_W'(s_data);

  dist_fix_sat_add #(.W(ACC_W)) u_add (
    .a   (acc),
    .b   (s_ext),
    .sum (sum),
    .ovf (add_ovf)
  );

  assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

  // Output path is computed from the running sum so the last beat lands in one edge.
  assign shifted   = sum >>> SHIFT;
  assign wide      = 64'(shifted);
  assign clamped   = sat_narrow(wide, OUT_W);
  assign out_clamp = (clamped != wide);
  assign out_val   = OUT_W'(clamped);

  // Handshake flags decode the state register only; m_ready never reaches s_ready.
  assign s_ready = (state == S_ACC);
  assign m_valid = (state == S_OUT);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state   <= S_ACC;
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      m_data  <= '0;
      m_ovf   <= 1'b0;
      m_count <= '0;
    end else begin
      case (state)
        S_ACC: begin
          if (s_valid) begin
            cnt <= cnt_inc;
            if (add_ovf) ovf <= 1'b1;
            if (s_last) begin
              m_data  <= out_val;
              m_ovf   <= ovf | add_ovf | out_clamp;
              m_count <= cnt_inc;
              state   <= S_OUT;
            end else begin
              acc <= sum;
            end
          end
        end
        S_OUT: begin
          if (m_ready) begin
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            state <= S_ACC;
          end
        end
        default: state <= S_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_dist_fix_sq_accum.sv
// Randomized bench: three instances (SHIFT=0, SHIFT=4, CNT_W=4) share stimulus
// and are compared against a plain-arithmetic frame model.
module tb_dist_fix_sq_accum;

  localparam longint AMAX = (64'sd1 <<< 39) - 1;
  localparam longint AMIN = -(64'sd1 <<< 39);
  localparam longint OMAX = (64'sd1 <<< 31) - 1;
  localparam longint OMIN = -(64'sd1 <<< 31);

  logic               ap_clk = 1'b0;
  logic               ap_rst_n;
  logic               s_valid, s_last, m_ready;
  logic signed [33:0] s_data;

  logic               s_ready0, s_ready4, s_readyc;
  logic               m_valid0, m_valid4, m_validc;
  logic signed [31:0] m_data0, m_data4, m_datac;
  logic               m_ovf0, m_ovf4, m_ovfc;
  logic [15:0]        m_count0, m_count4;
  logic [3:0]         m_countc;

  int nchk = 0;
  int nerr = 0;
  longint beats[$];

  always #5 ap_clk = ~ap_clk;

  dist_fix_sq_accum u_d0 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .s_valid(s_valid), .s_ready(s_ready0),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid0), .m_ready(m_ready),
    .m_data(m_data0), .m_ovf(m_ovf0), .m_count(m_count0));

  dist_fix_sq_accum #(.SHIFT(4)) u_d4 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .s_valid(s_valid), .s_ready(s_ready4),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid4), .m_ready(m_ready),
    .m_data(m_data4), .m_ovf(m_ovf4), .m_count(m_count4));

  dist_fix_sq_accum #(.CNT_W(4)) u_dc (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .s_valid(s_valid), .s_ready(s_readyc),
    .s_data(s_data), .s_last(s_last), .m_valid(m_validc), .m_ready(m_ready),
    .m_data(m_datac), .m_ovf(m_ovfc), .m_count(m_countc));

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Frame result from the arithmetic rules: saturating running sum, shift, clamp.
  function automatic void model(input int shift, input int cw, output longint data,
                                output longint ovf, output longint cnt);
    longint a, t, cmax;
    a = 0;
    ovf = 0;
    foreach (beats[i]) begin
      a = a + beats[i];
      if (a > AMAX) begin a = AMAX; ovf = 1; end
      else if (a < AMIN) begin a = AMIN; ovf = 1; end
    end
    t = a >>> shift;
    if (t > OMAX) begin data = OMAX; ovf = 1; end
    else if (t < OMIN) begin data = OMIN; ovf = 1; end
    else data = t;
    cmax = (64'sd1 <<< cw) - 1;
    cnt  = (beats.size() > cmax) ? cmax : longint'(beats.size());
  endfunction

  task automatic check_out(input string ph);
    longint d0, o0, c0, d4, o4, c4, dc, oc, cc;
    model(0, 16, d0, o0, c0);
    model(4, 16, d4, o4, c4);
    model(0, 4, dc, oc, cc);
    chk({ph, ".valid0"}, m_valid0, 1);
    chk({ph, ".valid4"}, m_valid4, 1);
    chk({ph, ".validc"}, m_validc, 1);
    chk({ph, ".sready"}, s_ready0, 0);
    chk({ph, ".data0"}, m_data0, d0);
    chk({ph, ".ovf0"}, m_ovf0, o0);
    chk({ph, ".cnt0"}, m_count0, c0);
    chk({ph, ".data4"}, m_data4, d4);
    chk({ph, ".ovf4"}, m_ovf4, o4);
    chk({ph, ".cnt4"}, m_count4, c4);
    chk({ph, ".datac"}, m_datac, dc);
    chk({ph, ".ovfc"}, m_ovfc, oc);
    chk({ph, ".cntc"}, m_countc, cc);
  endtask

  // Drive the queued beats with random bubbles, then hold m_ready low for 'hold'
  // cycles while junk beats are offered, then complete the handshake.
  task automatic run_frame(input int gap_max, input int hold);
    logic [63:0] r;
    for (int i = 0; i < beats.size(); i++) begin
      int gaps = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
      for (int g = 0; g < gaps; g++) begin
        r       = {$urandom, $urandom};
        s_valid = 1'b0;
        s_data  = r[33:0];
        s_last  = r[40];
        m_ready = r[41];
        @(posedge ap_clk); #1;
      end
      chk("beat.sready", s_ready0, 1);
      chk("beat.mvalid", m_valid0, 0);
      s_valid = 1'b1;
      s_data  = 34'(beats[i]);
      s_last  = (i == beats.size() - 1);
      @(posedge ap_clk); #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
    m_ready = (hold == 0);
    for (int h = 0; h < hold; h++) begin
      check_out("hold");
      r       = {$urandom, $urandom};
      s_valid = 1'b1;
      s_data  = r[33:0];
      s_last  = 1'b1;
      @(posedge ap_clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    check_out("hs");
    @(posedge ap_clk); #1;
    m_ready = 1'b0;
    chk("post.mvalid", m_valid0, 0);
    chk("post.sready", s_ready0, 1);
  endtask

  initial begin
    logic [63:0]        r;
    logic signed [33:0] d34;
    ap_rst_n = 1'b0;
    s_valid  = 1'b0;
    s_last   = 1'b0;
    s_data   = '0;
    m_ready  = 1'b0;
    #1;
    chk("rst.mvalid", m_valid0, 0);
    chk("rst.mdata", m_data0, 0);
    chk("rst.movf", m_ovf0, 0);
    chk("rst.mcount", m_count0, 0);
    repeat (2) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;

    beats = '{3, 4, 5};
    run_frame(0, 0);

    beats = '{-7};
    run_frame(0, 4);

    beats.delete();
    repeat (300) beats.push_back((64'sd1 <<< 33) - 1);
    run_frame(0, 1);

    beats = '{100, 60};
    run_frame(2, 1);

    beats.delete();
    repeat (20) beats.push_back(1);
    run_frame(1, 2);

    // Partial frame killed by reset: nothing of it may survive.
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      s_data  = 34'sd9;
      s_last  = 1'b0;
      @(posedge ap_clk); #1;
    end
    s_valid = 1'b0;
    #2 ap_rst_n = 1'b0;
    #1;
    chk("midrst.mvalid", m_valid0, 0);
    chk("midrst.mdata", m_data0, 0);
    chk("midrst.mcount", m_count0, 0);
    chk("midrst.movf", m_ovf0, 0);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    beats = '{1, 1};
    run_frame(0, 0);

    for (int f = 0; f < 25; f++) begin
      int len  = $urandom_range(12, 1);
      int mode = $urandom_range(2, 0);
      beats.delete();
      for (int i = 0; i < len; i++) begin
        r = {$urandom, $urandom};
        case (mode)
          0:       beats.push_back(longint'($urandom_range(2000, 0)) - 1000);
          1:       begin d34 = r[33:0]; beats.push_back(longint'(d34)); end
          default: beats.push_back((64'sd1 <<< 33) - 1 - longint'($urandom_range(100, 0)));
        endcase
      end
      run_frame(3, $urandom_range(3, 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
